// File: rtl/div_pkg.sv
// Shared definitions for the sequential signed divider: default operand width
// and the controller state encoding.
package div_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration on unsigned magnitudes: shift the
// next dividend bit into the partial remainder and subtract the divisor if it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0]   i_prem,
    input  logic             i_dbit,
    input  logic [WIDTH-1:0] i_divisor,
    output logic [WIDTH:0]   o_prem,
    output logic             o_qbit
);

    logic [WIDTH+1:0] w_shift;
    logic [WIDTH:0]   w_diff;

    // One extra bit on the shifted value keeps the compare exact for any remainder.
    assign w_shift = {i_prem, i_dbit};
    assign w_diff  = w_shift[WIDTH:0] - {1'b0, i_divisor};
    assign o_qbit  = (w_shift >= {2'b00, i_divisor});
    assign o_prem  = o_qbit ? w_diff : w_shift[WIDTH:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed divider: magnitudes are divided by a restoring loop, then
// signs are applied (quotient truncates toward zero, remainder follows dividend).
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [WIDTH-1:0] in1,
    input  logic signed [WIDTH-1:0] in2,
    input  logic                    inValid,
    input  logic                    en,
    output logic signed [WIDTH-1:0] quot,
    output logic signed [WIDTH-1:0] rem,
    output logic                    outValid,
    output logic                    busy,
    output logic                    divZero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]    CNT_INIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [WIDTH-1:0] ZERO_W   = '0;
    localparam logic [WIDTH:0]   ZERO_P   = '0;
    localparam logic [WIDTH-1:0] ALL_ONES = '1;

    div_state_e       r_state;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH:0]   r_prem;
    logic [WIDTH-1:0] r_dq;
    logic [WIDTH-1:0] r_dvs;
    logic             r_neg_q;
    logic             r_neg_r;
    logic             r_dz;

    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic [WIDTH:0]   w_prem_nxt;
    logic             w_qbit;

    // Unsigned magnitudes; the most-negative value maps to 2^(WIDTH-1) correctly.
    assign w_abs1 = in1[WIDTH-1] ? (ZERO_W - in1) : in1;
    assign w_abs2 = in2[WIDTH-1] ? (ZERO_W - in2) : in2;

    div_step #(.WIDTH(WIDTH)) u_step (
        .i_prem    (r_prem),
        .i_dbit    (r_dq[WIDTH-1]),
        .i_divisor (r_dvs),
        .o_prem    (w_prem_nxt),
        .o_qbit    (w_qbit)
    );

    // Controller, datapath and registered outputs; en low freezes everything.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_prem   <= '0;
            r_dq     <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            quot     <= '0;
            rem      <= '0;
            outValid <= 1'b0;
            busy     <= 1'b0;
            divZero  <= 1'b0;
        end else if (en) begin
            case (r_state)
                ST_IDLE: begin
                    outValid <= 1'b0;
                    if (inValid) begin
                        r_dq    <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_prem  <= '0;
                        r_neg_q <= in1[WIDTH-1] ^ in2[WIDTH-1];
                        r_neg_r <= in1[WIDTH-1];
                        r_dz    <= (in2 == '0);
                        r_cnt   <= CNT_INIT;
                        busy    <= 1'b1;
                        r_state <= ST_CALC;
                    end
                end
                ST_CALC: begin
                    // r_dq shifts dividend bits out the top and quotient bits in the bottom.
                    r_prem <= w_prem_nxt;
                    r_dq   <= {r_dq[WIDTH-2:0], w_qbit};
                    if (r_cnt == '0) begin
                        r_state <= ST_FIX;
                    end else begin
                        r_cnt <= r_cnt - CNT_ONE;
                    end
                end
                ST_FIX: begin
                    quot    <= r_dz ? ALL_ONES : (r_neg_q ? (ZERO_W - r_dq) : r_dq);
                    rem     <= WIDTH'(r_neg_r ? (ZERO_P - r_prem) : r_prem);
                    divZero <= r_dz;
                    r_state <= ST_DONE;
                end
                ST_DONE: begin
                    outValid <= 1'b1;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
                default: begin
                    outValid <= 1'b0;
                    busy     <= 1'b0;
                    r_state  <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: a latency/arithmetic reference model checked every cycle,
// directed cases with literal expectations, then randomized operands, en and reset.
module tb_seq_divider;

    localparam int W   = 8;
    localparam int LAT = W + 2;

    logic                clk = 1'b0;
    logic                reset = 1'b0;
    logic                en = 1'b0;
    logic                inValid = 1'b0;
    logic signed [W-1:0] in1 = '0;
    logic signed [W-1:0] in2 = '0;
    logic signed [W-1:0] quot;
    logic signed [W-1:0] rem;
    logic                outValid;
    logic                busy;
    logic                divZero;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Reference model state: enabled edges left in the current operation.
    int m_cnt = 0;
    bit m_ov  = 1'b0;
    int m_q   = 0;
    int m_r   = 0;
    int m_dz  = 0;
    int p_q   = 0;
    int p_r   = 0;
    int p_dz  = 0;

    seq_divider #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .in1      (in1),
        .in2      (in2),
        .inValid  (inValid),
        .en       (en),
        .quot     (quot),
        .rem      (rem),
        .outValid (outValid),
        .busy     (busy),
        .divZero  (divZero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int wrap(input int v);
        logic signed [W-1:0] t;
        t = v[W-1:0];
        return int'(t);
    endfunction

    // Signed division truncating toward zero; divide-by-zero gives -1 and the dividend.
    function automatic int ref_q(input int a, input int b);
        if (b == 0) return wrap(-1);
        return wrap(a / b);
    endfunction

    function automatic int ref_r(input int a, input int b);
        if (b == 0) return wrap(a);
        return wrap(a % b);
    endfunction

    function automatic logic [W-1:0] pick();
        logic [W-1:0] v;
        case ($urandom_range(0, 7))
            0: v = '0;
            1: v = '1;
            2: v = {1'b1, {(W-1){1'b0}}};
            3: v = {1'b0, {(W-1){1'b1}}};
            default: v = W'($urandom);
        endcase
        return v;
    endfunction

    // Model: an accepted pair produces its result LAT enabled edges later.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt <= 0;
            m_ov  <= 1'b0;
            m_q   <= 0;
            m_r   <= 0;
            m_dz  <= 0;
        end else if (en) begin
            if (m_cnt != 0) begin
                m_cnt <= m_cnt - 1;
                m_ov  <= (m_cnt == 1);
                if (m_cnt == 1) begin
                    m_q  <= p_q;
                    m_r  <= p_r;
                    m_dz <= p_dz;
                end
            end else begin
                m_ov <= 1'b0;
                if (inValid) begin
                    m_cnt <= LAT;
                    p_q   <= ref_q(int'(in1), int'(in2));
                    p_r   <= ref_r(int'(in1), int'(in2));
                    p_dz  <= (in2 == '0) ? 1 : 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("outValid", int'(outValid), int'(m_ov));
            check("busy", int'(busy), (m_cnt != 0) ? 1 : 0);
            if (m_ov) begin
                check("quot", int'(quot), m_q);
                check("rem", int'(rem), m_r);
                check("divZero", int'(divZero), m_dz);
            end
        end
    end

    task automatic run_op(input int a, input int b, input int eq, input int er,
                          input int edz, input string tag);
        int lat;
        @(posedge clk); #1;
        in1 = a[W-1:0];
        in2 = b[W-1:0];
        inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        lat = 0;
        while (!outValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, " latency"}, lat, LAT);
        check({tag, " quot"}, int'(quot), eq);
        check({tag, " rem"}, int'(rem), er);
        check({tag, " divZero"}, int'(divZero), edz);
    endtask

    initial begin
        int lat;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("reset quot", int'(quot), 0);
        check("reset rem", int'(rem), 0);
        check("reset busy", int'(busy), 0);
        check("reset outValid", int'(outValid), 0);
        reset = 1'b1;
        en = 1'b1;

        run_op(100, 7, 14, 2, 0, "100/7");
        run_op(-7, 2, -3, -1, 0, "-7/2");
        run_op(7, -2, -3, 1, 0, "7/-2");
        run_op(45, 0, -1, 45, 1, "45/0");
        run_op(-128, -1, -128, 0, 0, "-128/-1");
        run_op(-128, 3, -42, -2, 0, "-128/3");
        run_op(-100, 0, -1, -100, 1, "-100/0");

        // en dropped for 3 edges mid-calculation; a pair offered while busy is ignored.
        @(posedge clk); #1;
        in1 = 8'sd100; in2 = 8'sd7; inValid = 1'b1;
        @(posedge clk); #1;
        in1 = 8'sd50; in2 = 8'sd5;
        lat = 0;
        while (!outValid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (lat == 2) inValid = 1'b0;
            if (lat == 3) en = 1'b0;
            if (lat == 6) en = 1'b1;
        end
        check("stall latency", lat, LAT + 3);
        check("stall quot", int'(quot), 14);
        check("stall rem", int'(rem), 2);
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("outValid held while en low", int'(outValid), 1);
        en = 1'b1;

        // Reset in the middle of an operation aborts it.
        @(posedge clk); #1;
        in1 = 8'sd100; in2 = 8'sd7; inValid = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("abort quot", int'(quot), 0);
        check("abort rem", int'(rem), 0);
        check("abort busy", int'(busy), 0);
        check("abort outValid", int'(outValid), 0);
        check("abort divZero", int'(divZero), 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b1;
        repeat (15) begin
            @(posedge clk); #1;
            check("no stray outValid", int'(outValid), 0);
        end
        run_op(15, 4, 3, 3, 0, "15/4");

        // Randomized operands, enable, valid and occasional reset pulses.
        repeat (4000) begin
            @(posedge clk); #1;
            en      = ($urandom_range(0, 7) != 0);
            inValid = ($urandom_range(0, 2) == 0);
            in1     = pick();
            in2     = pick();
            reset   = ($urandom_range(0, 499) != 0);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        en = 1'b1;
        inValid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
